// File: rtl/sdpram_rd_checker.sv
// Read-side self-test for the simple dual-port RAM wrappers: sweeps every read address once and
// checks the decrementing fill pattern. Optional first-error capture: define SDPRAM_CHK_FIRST_ERR_EN.
module sdpram_rd_checker #(
  parameter int RD_ADDR_WIDTH = 10,
  parameter int RD_DATA_WIDTH = 8,
  parameter int OUTPUT_REG    = 0,
  parameter int ERR_CNT_WIDTH = 3
) (
  input  logic                     wr_clk,
  input  logic                     tb_wr_rst,
  input  logic                     start,
  output logic                     rd_en,
  output logic [RD_ADDR_WIDTH-1:0] rd_addr,
  output logic                     rd_oce,
  input  logic [RD_DATA_WIDTH-1:0] rd_data,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
`ifdef SDPRAM_CHK_FIRST_ERR_EN
  ,
  output logic                     first_err_vld,
  output logic [RD_ADDR_WIDTH-1:0] first_err_addr,
  output logic [RD_DATA_WIDTH-1:0] first_err_data
`endif
);

  localparam int LAT = 1 + OUTPUT_REG;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_e;

  state_e                               state_q, state_d;
  logic [RD_ADDR_WIDTH-1:0]             addr_q, addr_d;
  logic [1:0]                           drain_q, drain_d;
  logic [ERR_CNT_WIDTH-1:0]             err_q, err_d;
  logic [LAT-1:0]                       vld_q, vld_d;
  logic [LAT-1:0][RD_DATA_WIDTH-1:0]    exp_q, exp_d;

  logic start_ok;
  logic mismatch;

  assign start_ok = start && (state_q == IDLE || state_q == DONE);
  // X on rd_data must count as an error in simulation, hence the case inequality.
  assign mismatch = vld_q[LAT-1] && (rd_data !== exp_q[LAT-1]);

  // NOTE: every variable assigned in an always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    err_d   = err_q;

    if (mismatch && err_q != '1) err_d = err_q + 1'b1;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SWEEP;
          addr_d  = '0;
          err_d   = '0;
        end
      end
      SWEEP: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == '1) begin
          state_d = DRAIN;
          drain_d = 2'd0;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'(LAT - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Check pipeline: the expected word travels alongside the read, LAT stages deep.
  always_comb begin
    vld_d    = '0;
    exp_d    = '0;
    vld_d[0] = rd_en;
    exp_d[0] = ~RD_DATA_WIDTH'(addr_q);
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      exp_d[i] = exp_q[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the
  // edge, independent of statement order.
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      drain_q <= 2'd0;
      err_q   <= '0;
      // NOTE: the pipeline is reset, not just its valid bits, so a reset mid-sweep flushes it
      // completely and nothing stale can be compared afterwards.
      vld_q   <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      exp_q   <= exp_d;
    end
  end

`ifdef SDPRAM_CHK_FIRST_ERR_EN
  logic [LAT-1:0][RD_ADDR_WIDTH-1:0] padr_q, padr_d;
  logic                              fe_vld_q, fe_vld_d;
  logic [RD_ADDR_WIDTH-1:0]          fe_addr_q, fe_addr_d;
  logic [RD_DATA_WIDTH-1:0]          fe_data_q, fe_data_d;

  always_comb begin
    padr_d    = '0;
    padr_d[0] = addr_q;
    for (int i = 1; i < LAT; i++) padr_d[i] = padr_q[i-1];

    fe_vld_d  = fe_vld_q;
    fe_addr_d = fe_addr_q;
    fe_data_d = fe_data_q;
    if (start_ok) begin
      fe_vld_d  = 1'b0;
      fe_addr_d = '0;
      fe_data_d = '0;
    end else if (mismatch && !fe_vld_q) begin
      fe_vld_d  = 1'b1;
      fe_addr_d = padr_q[LAT-1];
      fe_data_d = rd_data;
    end
  end

  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      padr_q    <= '0;
      fe_vld_q  <= 1'b0;
      fe_addr_q <= '0;
      fe_data_q <= '0;
    end else begin
      padr_q    <= padr_d;
      fe_vld_q  <= fe_vld_d;
      fe_addr_q <= fe_addr_d;
      fe_data_q <= fe_data_d;
    end
  end

  assign first_err_vld  = fe_vld_q;
  assign first_err_addr = fe_addr_q;
  assign first_err_data = fe_data_q;
`endif

  assign rd_en   = (state_q == SWEEP);
  assign rd_addr = addr_q;
  assign busy    = (state_q == SWEEP) || (state_q == DRAIN);
  assign rd_oce  = (OUTPUT_REG != 0) && busy;
  assign done    = (state_q == DONE);
  assign pass    = done && (err_q == '0);
  assign err_cnt = err_q;

endmodule

// File: tb/tb_sdpram_rd_checker.sv
// Bench for sdpram_rd_checker: two instances (read latency 1 and 2) over one shared pattern RAM,
// random corruptions scored against a whole-sweep reference model.
module tb_sdpram_rd_checker;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int EW = 3;
  localparam int N  = 1 << AW;
  localparam int SAT = (1 << EW) - 1;

  logic wr_clk = 1'b0;
  logic tb_wr_rst;
  logic start;
  always #5 wr_clk = ~wr_clk;

  logic [DW-1:0] mem [N];

  logic          rd_en0, rd_oce0, busy0, done0, pass0;
  logic [AW-1:0] rd_addr0;
  logic [DW-1:0] rd_data0;
  logic [EW-1:0] err0;
  logic          rd_en1, rd_oce1, busy1, done1, pass1;
  logic [AW-1:0] rd_addr1;
  logic [DW-1:0] rd_data1, ram1_s1;
  logic [EW-1:0] err1;
`ifdef SDPRAM_CHK_FIRST_ERR_EN
  logic          fev0, fev1;
  logic [AW-1:0] fea0, fea1;
  logic [DW-1:0] fed0, fed1;
`endif

  sdpram_rd_checker #(.RD_ADDR_WIDTH(AW), .RD_DATA_WIDTH(DW), .OUTPUT_REG(0), .ERR_CNT_WIDTH(EW)) u_dut0 (
    .wr_clk(wr_clk), .tb_wr_rst(tb_wr_rst), .start(start), .rd_en(rd_en0), .rd_addr(rd_addr0),
    .rd_oce(rd_oce0), .rd_data(rd_data0), .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0)
`ifdef SDPRAM_CHK_FIRST_ERR_EN
    , .first_err_vld(fev0), .first_err_addr(fea0), .first_err_data(fed0)
`endif
  );

  sdpram_rd_checker #(.RD_ADDR_WIDTH(AW), .RD_DATA_WIDTH(DW), .OUTPUT_REG(1), .ERR_CNT_WIDTH(EW)) u_dut1 (
    .wr_clk(wr_clk), .tb_wr_rst(tb_wr_rst), .start(start), .rd_en(rd_en1), .rd_addr(rd_addr1),
    .rd_oce(rd_oce1), .rd_data(rd_data1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1)
`ifdef SDPRAM_CHK_FIRST_ERR_EN
    , .first_err_vld(fev1), .first_err_addr(fea1), .first_err_data(fed1)
`endif
  );

  // RAM read ports: latency 1, and latency 2 with output register gated by rd_oce.
  always @(posedge wr_clk) if (rd_en0) rd_data0 <= mem[rd_addr0];
  always @(posedge wr_clk) begin
    if (rd_en1)  ram1_s1  <= mem[rd_addr1];
    if (rd_oce1) rd_data1 <= ram1_s1;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pattern(input int a);
    return DW'((1 << DW) - 1 - a);
  endfunction

  task automatic fill_clean();
    for (int a = 0; a < N; a++) mem[a] = pattern(a);
  endtask

  function automatic int count_bad();
    int c = 0;
    for (int a = 0; a < N; a++) if (mem[a] !== pattern(a)) c++;
    return c;
  endfunction

  function automatic int first_bad();
    for (int a = 0; a < N; a++) if (mem[a] !== pattern(a)) return a;
    return -1;
  endfunction

  task automatic corrupt_random(input int k);
    while (count_bad() < k) begin
      int a;
      a = $urandom_range(N - 1);
      mem[a] = pattern(a) ^ DW'($urandom_range((1 << DW) - 1, 1));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".out0"}, {rd_en0, rd_addr0, rd_oce0, busy0, done0, pass0, err0}, 0);
    check({tag, ".out1"}, {rd_en1, rd_addr1, rd_oce1, busy1, done1, pass1, err1}, 0);
`ifdef SDPRAM_CHK_FIRST_ERR_EN
    check({tag, ".fe0"}, {fev0, fea0, fed0}, 0);
    check({tag, ".fe1"}, {fev1, fea1, fed1}, 0);
`endif
  endtask

  // One full sweep on both instances; optional extra start pulses at cycle offsets ign1/ign2.
  task automatic run_sweep(input string tag, input int ign1, input int ign2);
    int bad, exp_err, c0, c1, b0, b1, oce_bad0, oce_bad1;
    bad = count_bad();
    exp_err = (bad > SAT) ? SAT : bad;
    c0 = -1; c1 = -1; b0 = 0; b1 = 0; oce_bad0 = 0; oce_bad1 = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ".first_issue0"}, {rd_en0, rd_addr0, done0, err0}, {1'b1, AW'(0), 1'b0, EW'(0)});
    check({tag, ".first_issue1"}, {rd_en1, rd_addr1, done1, err1}, {1'b1, AW'(0), 1'b0, EW'(0)});
    for (int k = 1; k < 3000 && (c0 < 0 || c1 < 0); k++) begin
      if (busy0) b0++;
      if (busy1) b1++;
      if (rd_oce0 !== 1'b0) oce_bad0++;
      if (rd_oce1 !== busy1) oce_bad1++;
      if (done0 && c0 < 0) c0 = k;
      if (done1 && c1 < 0) c1 = k;
      start = (k == ign1 || k == ign2);
      tick();
    end
    start = 1'b0;
    check({tag, ".cycles0"}, c0, N + 2);
    check({tag, ".cycles1"}, c1, N + 3);
    check({tag, ".busy0"}, b0, N + 1);
    check({tag, ".busy1"}, b1, N + 2);
    check({tag, ".oce"}, {oce_bad0, oce_bad1}, 0);
    check({tag, ".err0"}, err0, exp_err);
    check({tag, ".err1"}, err1, exp_err);
    check({tag, ".pass"}, {pass0, pass1}, {2{bad == 0}});
`ifdef SDPRAM_CHK_FIRST_ERR_EN
    if (bad == 0) begin
      check({tag, ".fe0"}, {fev0, fea0, fed0}, 0);
      check({tag, ".fe1"}, {fev1, fea1, fed1}, 0);
    end else begin
      check({tag, ".fe0"}, {fev0, fea0, fed0}, {1'b1, AW'(first_bad()), mem[first_bad()]});
      check({tag, ".fe1"}, {fev1, fea1, fed1}, {1'b1, AW'(first_bad()), mem[first_bad()]});
    end
`endif
  endtask

  initial begin
    int waited;
    tb_wr_rst = 1'b1;
    start = 1'b0;
    fill_clean();
    repeat (3) tick();
    check_all_zero("reset");
    tb_wr_rst = 1'b0;
    tick();

    run_sweep("clean", -1, -1);

    mem[5] = 8'h00;
    run_sweep("addr5", -1, -1);

    fill_clean();
    corrupt_random(10);
    run_sweep("sat10", -1, -1);

    // Starting from DONE with err_cnt saturated; stray starts mid-sweep must be ignored.
    fill_clean();
    run_sweep("ignore_start", 50, 400);

    // Start on the last drain cycle of the latency-1 instance (first drain of the other).
    run_sweep("start_last_drain", N + 1, -1);
    repeat (3) tick();
    check("held_done", {done0, busy0, done1, busy1}, 4'b1010);

    mem[7] = 8'h55;
    start = 1'b1;
    tick();
    start = 1'b0;
    waited = 0;
    while (rd_addr0 != AW'(300) && waited < 2000) begin
      tick();
      waited++;
    end
    check("reach_300", rd_addr0, 300);
    tb_wr_rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    repeat (2) tick();
    tb_wr_rst = 1'b0;
    tick();
    fill_clean();
    run_sweep("after_reset", -1, -1);

    for (int r = 0; r < 3; r++) begin
      fill_clean();
      corrupt_random($urandom_range(9));
      run_sweep($sformatf("rand%0d", r), -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
